// File: rtl/mdu_pkg.sv
// mdu_pkg: operation codes and widths shared by the multiply/divide unit.
package mdu_pkg;
  localparam int ARGS_WIDTH = 4;
  localparam logic [ARGS_WIDTH-1:0] MDU_TYPE_MUL    = 4'd0;
  localparam logic [ARGS_WIDTH-1:0] MDU_TYPE_MULH   = 4'd1;
  localparam logic [ARGS_WIDTH-1:0] MDU_TYPE_MULHSU = 4'd2;
  localparam logic [ARGS_WIDTH-1:0] MDU_TYPE_MULHU  = 4'd3;
  localparam logic [ARGS_WIDTH-1:0] MDU_TYPE_DIV    = 4'd4;
  localparam logic [ARGS_WIDTH-1:0] MDU_TYPE_DIVU   = 4'd5;
  localparam logic [ARGS_WIDTH-1:0] MDU_TYPE_REM    = 4'd6;
  localparam logic [ARGS_WIDTH-1:0] MDU_TYPE_REMU   = 4'd7;
endpackage

// File: rtl/mdu_core.sv
// mdu_core: shared bit-serial shift-add multiplier / restoring divider on unsigned magnitudes.
module mdu_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic         div,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         done
);
  localparam int CW = $clog2(W) + 1;
  logic [W-1:0] a_q, a_d;
  logic [2*W-1:0] acc_q, acc_d, step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d;
  logic [W:0] sum, rsh, diff;
  // acc holds {product high, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    rsh = acc_q[2*W-1:W-1];
    diff = rsh - {1'b0, a_q};
    step = div_q ? {(diff[W] ? rsh[W-1:0] : diff[W-1:0]), acc_q[W-2:0], ~diff[W]}
                 : {sum, acc_q[W-1:1]};
    a_d = start ? a_in : a_q;
    div_d = start ? div : div_q;
    acc_d = start ? {{W{1'b0}}, b_in} : en ? step : acc_q;
    cnt_d = start ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      a_q <= a_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  assign lo = step[W-1:0];
  assign hi = step[2*W-1:W];
  assign done = en && cnt_q == CW'(W - 1);
endmodule

// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit with handshake, sign handling and fast path.
module mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_sys_flush,
  input  logic                  i_idu_valid,
  output logic                  o_mdu_ready,
  input  logic [ARGS_WIDTH-1:0] i_idu_ctr_mdu_type,
  input  logic [DATA_WIDTH-1:0] i_idu_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
  output logic                  o_sys_valid,
  input  logic                  i_sys_ready,
  output logic [DATA_WIDTH-1:0] o_mdu_res,
  output logic                  o_mdu_busy
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] res_q, res_d, mag1, mag2, fast_res, lo, hi, sel, hi_neg, fin;
  logic neg_q, neg_d, hi_q, hi_d, mul_q, mul_d;
  logic [ARGS_WIDTH-1:0] op;
  logic accept, s1, s2, n1, n2, fast, done;
  assign op = i_idu_ctr_mdu_type;
  assign o_mdu_ready = state_q == IDLE;
  assign o_mdu_busy = state_q != IDLE;
  assign o_sys_valid = state_q == DONE;
  assign o_mdu_res = res_q;
  assign accept = i_idu_valid && o_mdu_ready && !i_sys_flush;
  always_comb begin
    s1 = op == MDU_TYPE_MULH || op == MDU_TYPE_MULHSU || op == MDU_TYPE_DIV || op == MDU_TYPE_REM;
    s2 = op == MDU_TYPE_MULH || op == MDU_TYPE_DIV || op == MDU_TYPE_REM;
    n1 = s1 && i_idu_rs1_data[W-1];
    n2 = s2 && i_idu_rs2_data[W-1];
    mag1 = n1 ? -i_idu_rs1_data : i_idu_rs1_data;
    mag2 = n2 ? -i_idu_rs2_data : i_idu_rs2_data;
    fast = op > MDU_TYPE_REMU || (op >= MDU_TYPE_DIV && i_idu_rs2_data == '0) ||
           ((op == MDU_TYPE_DIV || op == MDU_TYPE_REM) && i_idu_rs1_data == MIN && i_idu_rs2_data == '1);
    fast_res = op > MDU_TYPE_REMU ? '0 :
               i_idu_rs2_data == '0 ? ((op == MDU_TYPE_DIV || op == MDU_TYPE_DIVU) ? '1 : i_idu_rs1_data) :
               op == MDU_TYPE_DIV ? MIN : '0;
    sel = hi_q ? hi : lo;
    // high half of the 2W-bit two's complement of {hi, lo}
    hi_neg = ~hi + {{(W-1){1'b0}}, lo == '0};
    fin = !neg_q ? sel : (mul_q && hi_q) ? hi_neg : -sel;
    state_d = state_q;
    res_d = res_q;
    neg_d = neg_q;
    hi_d = hi_q;
    mul_d = mul_q;
    if (i_sys_flush) state_d = IDLE;
    else if (accept) begin
      state_d = fast ? DONE : CALC;
      res_d = fast ? fast_res : res_q;
      neg_d = op == MDU_TYPE_REM ? n1 : n1 ^ n2;
      hi_d = op == MDU_TYPE_MULH || op == MDU_TYPE_MULHSU || op == MDU_TYPE_MULHU ||
             op == MDU_TYPE_REM || op == MDU_TYPE_REMU;
      mul_d = op < MDU_TYPE_DIV;
    end else if (state_q == CALC && done) begin
      state_d = DONE;
      res_d = fin;
    end else if (state_q == DONE && i_sys_ready) state_d = IDLE;
  end
  always_ff @(posedge i_sys_clk or posedge i_sys_rst)
    if (i_sys_rst) begin
      state_q <= IDLE;
      res_q <= '0;
      neg_q <= 1'b0;
      hi_q <= 1'b0;
      mul_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      mul_q <= mul_d;
    end
  mdu_core #(.W(W)) u_core (
    .clk  (i_sys_clk),
    .rst  (i_sys_rst),
    .start(accept),
    .en   (state_q == CALC),
    .div  (op >= MDU_TYPE_DIV),
    .a_in (mag2),
    .b_in (mag1),
    .lo   (lo),
    .hi   (hi),
    .done (done)
  );
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized scoreboard bench for mdu against an arithmetic reference model.
module tb_mdu;
  import mdu_pkg::*;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  logic clk = 0, rst, flush, vld, rdy_in;
  logic [ARGS_WIDTH-1:0] op;
  logic [W-1:0] a, b, res;
  logic ready, valid, busy;
  int cyc = 0, errors = 0, checks = 0, hs_cyc = 0;
  typedef struct {logic [W-1:0] res; int lat; int acc; int stall;} exp_t;
  exp_t q[$];

  mdu #(.DATA_WIDTH(W)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_sys_flush(flush), .i_idu_valid(vld),
    .o_mdu_ready(ready), .i_idu_ctr_mdu_type(op), .i_idu_rs1_data(a), .i_idu_rs2_data(b),
    .o_sys_valid(valid), .i_sys_ready(rdy_in), .o_mdu_res(res), .o_mdu_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [W-1:0] model(logic [ARGS_WIDTH-1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    longint sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    p = 0;
    case (o)
      MDU_TYPE_MUL:    p = ux * uy;
      MDU_TYPE_MULH:   p = (sx * sy) >>> 32;
      MDU_TYPE_MULHSU: p = (sx * uy) >>> 32;
      MDU_TYPE_MULHU:  p = (ux * uy) >> 32;
      MDU_TYPE_DIV:    p = (y == 0) ? -1 : (x == MIN && y == '1) ? sx : sx / sy;
      MDU_TYPE_DIVU:   p = (y == 0) ? -1 : ux / uy;
      MDU_TYPE_REM:    p = (y == 0) ? sx : (x == MIN && y == '1) ? 0 : sx % sy;
      MDU_TYPE_REMU:   p = (y == 0) ? ux : ux % uy;
      default:         p = 0;
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_fast(logic [ARGS_WIDTH-1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    return o > MDU_TYPE_REMU || (o >= MDU_TYPE_DIV && y == 0) ||
           ((o == MDU_TYPE_DIV || o == MDU_TYPE_REM) && x == MIN && y == '1);
  endfunction

  task automatic issue(logic [ARGS_WIDTH-1:0] o, logic [W-1:0] x, logic [W-1:0] y,
                       int stall, bit push, bit b2b);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected 1", n);
      return;
    end
    op = o;
    a = x;
    b = y;
    vld = 1;
    if (push) q.push_back('{model(o, x, y), is_fast(o, x, y) ? 1 : W + 1, cyc + 1, stall});
    if (b2b) chk("back_to_back_accept", cyc + 1, hs_cyc + 1);
    @(negedge clk);
    vld = 0;
    op = ARGS_WIDTH'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return MIN;
      2: return '1;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;
    rdy_in = 0;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid=1 res=%h, expected no result", res);
        end else begin
          e = q.pop_front();
          chk("result", res, e.res);
          chk("latency", cyc - e.acc + 1, e.lat);
          for (int i = 0; i < e.stall; i++) begin
            @(negedge clk);
            chk("stall_res_stable", res, e.res);
            chk("stall_ready_low", ready, 0);
            chk("stall_valid_high", valid, 1);
          end
        end
        rdy_in = 1;
        hs_cyc = cyc + 1;
        @(negedge clk);
        rdy_in = 0;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_res"}, res, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1;
    flush = 0;
    vld = 0;
    op = 0;
    a = 0;
    b = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    issue(MDU_TYPE_MUL, 7, 32'hFFFF_FFFD, 0, 1, 0);
    issue(MDU_TYPE_MULH, MIN, MIN, 0, 1, 0);
    issue(MDU_TYPE_MULHU, MIN, MIN, 0, 1, 0);
    issue(MDU_TYPE_MULHSU, '1, '1, 0, 1, 0);
    issue(MDU_TYPE_DIV, -7, 2, 0, 1, 0);
    issue(MDU_TYPE_REM, -7, 2, 0, 1, 0);
    issue(MDU_TYPE_DIVU, 100, 7, 0, 1, 0);
    issue(MDU_TYPE_REMU, 100, 7, 0, 1, 0);
    issue(MDU_TYPE_DIVU, 5, 0, 0, 1, 0);
    issue(MDU_TYPE_REM, 5, 0, 0, 1, 0);
    issue(MDU_TYPE_DIV, MIN, '1, 0, 1, 0);
    issue(MDU_TYPE_REM, MIN, '1, 0, 1, 0);
    issue(4'd9, 123, 456, 0, 1, 0);
    drain();

    issue(MDU_TYPE_DIVU, 100, 7, 10, 1, 0);
    issue(MDU_TYPE_REMU, 100, 7, 0, 1, 1);
    drain();

    issue(MDU_TYPE_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    repeat (5) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", busy, 0);
    chk("flush_ready", ready, 1);
    repeat (W + 5) @(negedge clk);
    issue(MDU_TYPE_DIVU, 9, 3, 0, 1, 0);
    drain();

    for (int i = 0; i < 60; i++)
      issue(ARGS_WIDTH'($urandom_range(0, 9)), rand_opnd(), rand_opnd(), $urandom_range(0, 3), 1, 0);
    drain();

    issue(MDU_TYPE_MULHU, $urandom, $urandom, 0, 0, 0);
    repeat (10) @(negedge clk);
    #2 rst = 1;
    #1 chk_reset_outputs("async_reset");
    @(posedge clk);
    #1 chk_reset_outputs("reset_held");
    #1 rst = 0;
    issue(MDU_TYPE_DIVU, 9, 3, 0, 1, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
